// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the general timer's input conditioner.
//   edge_sel_e : per-channel edge selection (none / rising / falling / both)
//   SYNC_MIN / SYNC_MAX : legal range of synchroniser depth
//   edge_pulse(): decides whether a committed level change raises a pulse
// Optional feature macro used by the conditioner: TIMER_INCOND_GLITCH_CNT_EN
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  // Pulse decision for a commit; rising = 1 when the new filtered level is 1.
  function automatic logic edge_pulse(input edge_sel_e sel, input logic rising);
    logic hit;
    case (sel)
      EDGE_NONE: hit = 1'b0;
      EDGE_RISE: hit = rising;
      EDGE_FALL: hit = ~rising;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/timer_incond_ch.sv
// -----------------------------------------------------------------------------
// timer_incond_ch
// One input-conditioner channel: synchroniser, glitch filter, edge detect and
// (with TIMER_INCOND_GLITCH_CNT_EN) an 8-bit saturating glitch counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pin          : asynchronous input pin
//   filt_len     : stable-time threshold (cycles beyond the first deviation)
//   edge_sel     : which committed edges raise pulse
//   level        : filtered level (registered)
//   pulse        : one-cycle pulse on a selected committed edge (registered)
//   glitch       : one-cycle pulse when a deviation returns before commit
//   glitch_clr   : (feature) synchronous clear of glitch_cnt
//   glitch_cnt   : (feature) saturating count of glitch pulses
// -----------------------------------------------------------------------------
module timer_incond_ch
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin,
  input  logic [FILT_W-1:0] filt_len,
  input  edge_sel_e         edge_sel,
  output logic              level,
  output logic              pulse,
`ifdef TIMER_INCOND_GLITCH_CNT_EN
  input  logic              glitch_clr,
  output logic [7:0]        glitch_cnt,
`endif
  output logic              glitch
);

  // Out-of-range depths are clamped into the legal range rather than
  // producing a broken synchroniser.
  localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                          (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;

  logic [STAGES-1:0] sync;
  logic [FILT_W-1:0] cnt;
  logic              s;

  assign s = sync[STAGES-1];

  // Synchroniser chain, filter counter, filtered level and edge/glitch pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= {STAGES{1'b0}};
      cnt    <= {FILT_W{1'b0}};
      level  <= 1'b0;
      pulse  <= 1'b0;
      glitch <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      if (s == level) begin
        // A non-zero count here means the deviation went away before commit.
        glitch <= (cnt != {FILT_W{1'b0}});
        cnt    <= {FILT_W{1'b0}};
        pulse  <= 1'b0;
      end else if (cnt >= filt_len) begin
        // cnt < filt_len on every increment, so cnt cannot pass all-ones.
        level  <= s;
        cnt    <= {FILT_W{1'b0}};
        pulse  <= edge_pulse(edge_sel, s);
        glitch <= 1'b0;
      end else begin
        cnt    <= cnt + {{(FILT_W-1){1'b0}}, 1'b1};
        pulse  <= 1'b0;
        glitch <= 1'b0;
      end
    end
  end

`ifdef TIMER_INCOND_GLITCH_CNT_EN
  // Saturating glitch counter; clear wins over a coincident glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= 8'd0;
    end else if (glitch_clr) begin
      glitch_cnt <= 8'd0;
    end else if (glitch && (glitch_cnt != 8'd255)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end else begin
      glitch_cnt <= glitch_cnt;
    end
  end
`endif

endmodule

// File: rtl/timer_input_cond.sv
// -----------------------------------------------------------------------------
// timer_input_cond
// Input conditioner for the general timer's asynchronous external inputs.
// Generates NUM_CH independent timer_incond_ch channels sharing filt_len.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_i       : asynchronous input pins, one per channel
//   filt_len   : shared glitch-filter threshold (quasi-static)
//   edge_sel   : bits [2c+1:2c] select edges of channel c (00/01/10/11)
//   level_o    : filtered levels
//   pulse_o    : one-cycle pulses on selected committed edges
//   glitch_o   : one-cycle pulses on rejected glitches
//   glitch_clr : (TIMER_INCOND_GLITCH_CNT_EN) clear all glitch counters
//   glitch_cnt : (TIMER_INCOND_GLITCH_CNT_EN) 8 bits per channel, saturating
// Optional feature macro: TIMER_INCOND_GLITCH_CNT_EN
// -----------------------------------------------------------------------------
module timer_input_cond
  import timer_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   in_i,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [2*NUM_CH-1:0] edge_sel,
`ifdef TIMER_INCOND_GLITCH_CNT_EN
  input  logic                glitch_clr,
  output logic [8*NUM_CH-1:0] glitch_cnt,
`endif
  output logic [NUM_CH-1:0]   level_o,
  output logic [NUM_CH-1:0]   pulse_o,
  output logic [NUM_CH-1:0]   glitch_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_incond_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pin        (in_i[c]),
      .filt_len   (filt_len),
      .edge_sel   (edge_sel_e'(edge_sel[2*c +: 2])),
      .level      (level_o[c]),
      .pulse      (pulse_o[c]),
`ifdef TIMER_INCOND_GLITCH_CNT_EN
      .glitch_clr (glitch_clr),
      .glitch_cnt (glitch_cnt[8*c +: 8]),
`endif
      .glitch     (glitch_o[c])
    );
  end

endmodule

// File: tb/tb_timer_input_cond.sv
// -----------------------------------------------------------------------------
// tb_timer_input_cond
// Self-checking bench for timer_input_cond (NUM_CH=2, SYNC_STAGES=2, FILT_W=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_input_cond;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_i;
  logic [7:0] filt_len;
  logic [3:0] edge_sel;
  logic [1:0] level_o;
  logic [1:0] pulse_o;
  logic [1:0] glitch_o;
`ifdef TIMER_INCOND_GLITCH_CNT_EN
  logic        glitch_clr;
  logic [15:0] glitch_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_input_cond #(
    .NUM_CH      (2),
    .SYNC_STAGES (2),
    .FILT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_i       (in_i),
    .filt_len   (filt_len),
    .edge_sel   (edge_sel),
`ifdef TIMER_INCOND_GLITCH_CNT_EN
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt),
`endif
    .level_o    (level_o),
    .pulse_o    (pulse_o),
    .glitch_o   (glitch_o)
  );

  // Single-pulse stimulus record on ch0 with expected observations.
  typedef struct {
    logic [7:0] fl;
    logic [1:0] es;
    int         width;
    int         exp_lvl;
    int         exp_pulses;
    int         exp_glitches;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic quiesce(input int n);
    in_i = 2'b00;
    repeat (n) tick();
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int p0, p1, g0, lvl;
    p0 = 0; p1 = 0; g0 = 0; lvl = 0;
    filt_len = v.fl;
    edge_sel = {2'b11, v.es};
    quiesce(30);
    in_i[0] = 1'b1;
    for (int t = 0; t < v.width + 2 * int'(v.fl) + 20; t++) begin
      if (t == v.width) in_i[0] = 1'b0;
      tick();
      if (pulse_o[0])  p0++;
      if (pulse_o[1])  p1++;
      if (glitch_o[0]) g0++;
      if (level_o[0])  lvl = 1;
    end
    check($sformatf("row%0d_level_seen", idx), lvl, v.exp_lvl);
    check($sformatf("row%0d_pulses", idx), p0, v.exp_pulses);
    check($sformatf("row%0d_glitches", idx), g0, v.exp_glitches);
    check($sformatf("row%0d_ch1_quiet", idx), p1, 0);
    check($sformatf("row%0d_final_level", idx), int'(level_o[0]), 0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int np, wrong, prev, first_t, second_t;

    //        fl     es     width lvl pulses glitches
    vecs[0] = '{8'd5, 2'b11, 3,  0, 0, 1};
    vecs[1] = '{8'd5, 2'b11, 5,  0, 0, 1};
    vecs[2] = '{8'd5, 2'b11, 6,  1, 2, 0};
    vecs[3] = '{8'd0, 2'b01, 1,  1, 1, 0};
    vecs[4] = '{8'd0, 2'b10, 1,  1, 1, 0};
    vecs[5] = '{8'd0, 2'b00, 4,  1, 0, 0};
    vecs[6] = '{8'd3, 2'b01, 10, 1, 1, 0};
    vecs[7] = '{8'd2, 2'b11, 2,  0, 0, 1};
    vecs[8] = '{8'd8, 2'b11, 9,  1, 2, 0};

`ifdef TIMER_INCOND_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif

    // Reset with pins high, then full-latency rising commit on both channels.
    rst = 1'b1; in_i = 2'b11; filt_len = 8'd4; edge_sel = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_outputs_%0d", i), int'({level_o, pulse_o, glitch_o}), 0);
    end
    rst = 1'b0;
    repeat (6) tick();
    check("latency_before", int'(level_o), 0);
    tick();
    check("latency_level", int'(level_o), 3);
    check("latency_pulse", int'(pulse_o), 3);
    tick();
    check("pulse_one_cycle", int'(pulse_o), 0);
    check("level_held", int'(level_o), 3);
    in_i = 2'b00;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pulse_o != 2'b00) np++;
    end
    check("fall_suppressed_pulses", np, 0);
    check("fall_level", int'(level_o), 0);

    for (int r = 0; r < 9; r++) run_row(r, vecs[r]);

    // Threshold exactness: two pulses exactly 6 cycles apart.
    filt_len = 8'd5; edge_sel = 4'b0011;
    quiesce(30);
    np = 0; first_t = -1; second_t = -1;
    for (int t = 0; t < 40; t++) begin
      in_i[0] = (t < 6);
      tick();
      if (pulse_o[0]) begin
        np++;
        if (first_t < 0) first_t = t; else second_t = t;
      end
    end
    check("thresh_pulse_count", np, 2);
    check("thresh_pulse_gap", second_t - first_t, 6);

    // Edge select: falling only on ch1, square wave period 8, filt_len 0.
    filt_len = 8'd0; edge_sel = 4'b1000;
    quiesce(30);
    np = 0; wrong = 0; prev = int'(level_o[1]);
    for (int t = 0; t < 40; t++) begin
      in_i[1] = (t < 32) ? ((t % 8) < 4) : 1'b0;
      tick();
      if (pulse_o[1]) begin
        np++;
        if (!(prev == 1 && level_o[1] == 1'b0)) wrong++;
      end
      if (pulse_o[0]) wrong++;
      prev = int'(level_o[1]);
    end
    check("edgesel_fall_pulses", np, 4);
    check("edgesel_wrong_pulses", wrong, 0);

    // Mid-count threshold drop: cnt reaches 6 with filt_len 10, then 2.
    filt_len = 8'd10; edge_sel = 4'b0001;
    quiesce(30);
    in_i[0] = 1'b1;
    repeat (8) tick();
    check("midcount_before", int'(level_o[0]), 0);
    filt_len = 8'd2;
    tick();
    check("midcount_commit_level", int'(level_o[0]), 1);
    check("midcount_commit_pulse", int'(pulse_o[0]), 1);
    filt_len = 8'd5;
    quiesce(30);
    check("midcount_release", int'(level_o[0]), 0);

    // Reset during a count discards it; full latency restarts afterwards.
    in_i[0] = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rst_midcount_outputs", int'({level_o, pulse_o, glitch_o}), 0);
    rst = 1'b0;
    repeat (7) tick();
    check("rst_midcount_before", int'(level_o[0]), 0);
    tick();
    check("rst_midcount_commit", int'(level_o[0]), 1);
    quiesce(30);

`ifdef TIMER_INCOND_GLITCH_CNT_EN
    // Glitch counter: 1-cycle glitches with filt_len 1, saturation and clear.
    filt_len = 8'd1; edge_sel = 4'b0000;
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    for (int g = 0; g < 300; g++) begin
      in_i[0] = 1'b1;
      tick();
      in_i[0] = 1'b0;
      repeat (3) tick();
      if (g == 9) begin
        repeat (2) tick();
        check("gcnt_after_10", int'(glitch_cnt[7:0]), 10);
      end
    end
    repeat (4) tick();
    check("gcnt_saturated", int'(glitch_cnt[7:0]), 255);
    check("gcnt_ch1_zero", int'(glitch_cnt[15:8]), 0);
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    tick();
    check("gcnt_cleared", int'(glitch_cnt[7:0]), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_input_cond.md
# timer_input_cond

Input conditioner for the general timer's asynchronous external inputs (`ext_meas_i`, `capture_i`). It sits directly upstream of the timer wrapper and produces clean, filtered inputs for it. Each channel resynchronises its pin into `clk`, rejects glitches shorter than a programmable stable time, and emits a filtered level plus a one-cycle edge pulse. Either output type can drive the timer's capture and measurement inputs.

## Interface
Parameters:
- `NUM_CH`, 2: number of independent input channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel; legal values are 2 to 4.
- `FILT_W`, 8: width of the filter-length value and the per-channel stability counter.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset; synchronous, active-high.
- `in_i`  in  NUM_CH  asynchronous input pins.
- `filt_len`  in  FILT_W  glitch-filter threshold, shared by all channels; quasi-static.
- `edge_sel`  in  2*NUM_CH  per channel, bits [2c+1:2c]: 00 none, 01 rising, 10 falling, 11 both.
- `level_o`  out  NUM_CH  filtered, synchronised level.
- `pulse_o`  out  NUM_CH  one-cycle pulse on each selected filtered edge.
- `glitch_o`  out  NUM_CH  one-cycle pulse when a rejected glitch is detected.

## Operation
Synchroniser, per channel:
- `in_i[c]` passes through `SYNC_STAGES` flops. The last stage is called `s`.

Filter, per channel. State is the filtered level `f` (drives `level_o`) and a counter `cnt` of width `FILT_W`:
- `s == f`, `cnt == 0`: hold.
- `s == f`, `cnt != 0`: `cnt <= 0`; `glitch_o[c]` pulses next cycle (the deviation returned before commit).
- `s != f`, `cnt < filt_len`: `cnt <= cnt + 1`.
- `s != f`, `cnt >= filt_len`: commit. `f <= s` and `cnt <= 0`.
- With `filt_len = 0`, `f` tracks `s` with one cycle of delay and no filtering.
- `cnt` never exceeds `2^FILT_W - 1`. A commit always happens at or before that value, so the counter cannot wrap.

Edge detect, registered together with the commit:
- A commit of 0→1 pulses `pulse_o[c]` if `edge_sel[2c]` is set.
- A commit of 1→0 pulses `pulse_o[c]` if `edge_sel[2c+1]` is set.
- `edge_sel = 00` suppresses pulses. `level_o` still updates.

Boundary conditions:
- **`filt_len` changed mid-count:** the new value applies immediately. Because the compare is `>=`, a counter already above the new threshold commits on the next differing cycle.
- **`edge_sel` changed:** takes effect on the next commit. No pulse is generated retroactively.
- **`rst` asserted:** all synchroniser flops, `f`, `cnt`, `pulse_o` and `glitch_o` go to 0 at the next edge. An in-flight count is discarded.
- **Pin already high at reset release:** produces a normal rising commit after full latency. This is intended.
- **Channels:** fully independent, with no shared state except `filt_len`.

## Timing
- Reset values: `level_o = 0`, `pulse_o = 0`, `glitch_o = 0`.
- Latency from a clean `in_i` transition to `level_o`/`pulse_o` is `SYNC_STAGES + filt_len + 1` cycles, ±1 for synchroniser metastability resolution.
- `pulse_o` and `glitch_o` are high for exactly one cycle and registered. There is no back-to-back pulse on one channel closer than `filt_len + 1` cycles.
- A glitch shorter than `filt_len + 1` synchronised cycles never reaches `level_o`.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- **`TIMER_INCOND_GLITCH_CNT_EN` defined:**
  - Adds input port `glitch_clr` (1 bit) and output `glitch_cnt` (8*NUM_CH bits).
  - One 8-bit saturating counter per channel increments on each `glitch_o` pulse and sticks at 255.
  - `glitch_clr` zeroes all counters synchronously. If `glitch_clr` coincides with a glitch pulse, the result is 0.
  - Counters reset to 0.
- **Not defined:** these ports and counters do not exist. `glitch_o` is unchanged.

## Structure
- The shared package `timer_pkg` holds the edge-select typedef `edge_sel_e` (`EDGE_NONE`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`) and the `SYNC_STAGES` legal-range constants.
- One sub-module, `timer_incond_ch`: a single channel containing synchroniser, filter, edge detect and optional glitch counter. The top generates `NUM_CH` instances and slices `edge_sel`.

## Test plan
- **Reset behaviour:** `rst` high 3 cycles with `in_i = 2'b11` → all outputs 0 during reset. After release, with `filt_len = 4`, `level_o = 2'b11` after 2+4+1 = 7 cycles and `pulse_o` pulses once if `edge_sel = 01`.
- **Glitch rejection:** `filt_len = 5`, ch0 pulsed high for 3 cycles → `level_o[0]` stays 0, `pulse_o[0]` stays 0, `glitch_o[0]` pulses once.
- **Threshold exactness:** `filt_len = 5`, ch0 high for exactly 6 cycles then low for 10 → `level_o[0]` rises. With `edge_sel = 11`, exactly two pulses are separated by 6 cycles.
- **Edge select:** `edge_sel = 10`, `filt_len = 0`, square wave with period 8 on ch1 → `pulse_o[1]` only on falling commits, one per period.
- **Mid-count change:** `filt_len` drops from 10 to 2 while `cnt = 6` → commit on the next cycle with `s != f`.
- **Glitch counter:** with `TIMER_INCOND_GLITCH_CNT_EN`, 300 glitches → `glitch_cnt` for ch0 = 255. A `glitch_clr` pulse → 0.
